// File: rtl/clk_div_prog.sv
// -----------------------------------------------------------------------------
// clk_div_prog -- programmable integer frequency divider
//
// Divides clk_i by a WIDTH-bit divisor N (2 .. 2^WIDTH-1). The output is
// either a square wave (high for ceil(N/2) cycles, low for floor(N/2)) or a
// one-cycle pulse on the last cycle of each period. Divisor, mode and stop
// requests only take effect on a period boundary, so no runt period or glitch
// ever appears on the output.
//
// Ports
//   clk_i    : system clock, all flops rising-edge
//   rst_i    : asynchronous active-high reset
//   en_i     : run request (level)
//   div_i    : requested divisor, 0 and 1 are treated as 2
//   load_i   : one-cycle strobe capturing div_i into the pending divisor
//   mode_i   : 0 = square output, 1 = pulse output
//   f_out_o  : divided output (flop)
//   tick_o   : strobe on the last cycle of every period (flop)
//   busy_o   : high while a period is running or finishing (flop)
// -----------------------------------------------------------------------------
module clk_div_prog #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] div_i,
   input  logic             load_i,
   input  logic             mode_i,
   output logic             f_out_o,
   output logic             tick_o,
   output logic             busy_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_STOP = 2'd2
   } state_e;

   localparam logic [WIDTH-1:0] DIV_MIN = WIDTH'(2);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   // Divisors below 2 cannot form a period; they are promoted to 2.
   function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] r;
      if (d < DIV_MIN) begin
         r = DIV_MIN;
      end else begin
         r = d;
      end
      return r;
   endfunction

   state_e           state_q,   state_d;
   logic [WIDTH-1:0] cnt_q,     cnt_d;
   logic [WIDTH-1:0] pending_q, pending_d;
   logic [WIDTH-1:0] active_q,  active_d;
   logic             mode_q,    mode_d;
   logic             f_out_q,   f_out_d;
   logic             tick_q,    tick_d;
   logic             busy_q,    busy_d;

   logic [WIDTH-1:0] div_clamped_s;
   logic             last_s;
   logic [WIDTH-1:0] half_d_s;
   logic             term_d_s;
   logic             run_d_s;

   // Next-state logic: state, period counter, divisor and mode registers.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      active_d      = active_q;
      mode_d        = mode_q;
      div_clamped_s = clamp_div(div_i);
      last_s        = (state_q != S_IDLE) && (cnt_q == (active_q - ONE));
      pending_d     = load_i ? div_clamped_s : pending_q;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (en_i) begin
               state_d  = S_RUN;
               // A load on the start edge goes straight into the first period.
               active_d = load_i ? div_clamped_s : pending_q;
               mode_d   = mode_i;
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_RUN, S_STOP: begin
            if (last_s) begin
               cnt_d = '0;
               if ((state_q == S_STOP) && !en_i) begin
                  state_d = S_IDLE;
               end else begin
                  state_d  = en_i ? S_RUN : S_STOP;
                  active_d = load_i ? div_clamped_s : pending_q;
                  mode_d   = mode_i;
               end
            end else begin
               cnt_d   = cnt_q + ONE;
               state_d = en_i ? S_RUN : S_STOP;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output decode from next-state values so the ports come straight off flops.
   always_comb begin
      run_d_s  = (state_d != S_IDLE);
      half_d_s = (active_d >> 1) + {{(WIDTH-1){1'b0}}, active_d[0]};
      term_d_s = (cnt_d == (active_d - ONE));
      tick_d   = run_d_s && term_d_s;
      busy_d   = run_d_s;
      if (mode_d) begin
         f_out_d = run_d_s && term_d_s;
      end else begin
         f_out_d = run_d_s && (cnt_d < half_d_s);
      end
   end

   // State and output registers; reset is immediate, even mid-period.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         pending_q <= DIV_MIN;
         active_q  <= DIV_MIN;
         mode_q    <= 1'b0;
         f_out_q   <= 1'b0;
         tick_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         active_q  <= active_d;
         mode_q    <= mode_d;
         f_out_q   <= f_out_d;
         tick_q    <= tick_d;
         busy_q    <= busy_d;
      end
   end

   assign f_out_o = f_out_q;
   assign tick_o  = tick_q;
   assign busy_o  = busy_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// -----------------------------------------------------------------------------
// tb_clk_div_prog -- self-checking bench for clk_div_prog
//
// A period-level model (current period length, position in the period,
// pending divisor, stop request) predicts f_out/tick/busy for every cycle.
// Directed vectors carry hand-computed {f_out,tick,busy} expectations that
// pin the model to the intended waveforms.
// -----------------------------------------------------------------------------
module tb_clk_div_prog;

   logic       clk_i   = 1'b0;
   logic       rst_i   = 1'b0;
   logic       en_i    = 1'b0;
   logic [7:0] div_i   = 8'd0;
   logic       load_i  = 1'b0;
   logic       mode_i  = 1'b0;
   logic       f_out_o;
   logic       tick_o;
   logic       busy_o;

   clk_div_prog #(.WIDTH(8)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (en_i),
      .div_i   (div_i),
      .load_i  (load_i),
      .mode_i  (mode_i),
      .f_out_o (f_out_o),
      .tick_o  (tick_o),
      .busy_o  (busy_o)
   );

   always #5 clk_i = ~clk_i;

   // period-level model
   int m_busy = 0;
   int m_stop = 0;
   int m_pos  = 0;
   int m_n    = 2;
   int m_mode = 0;
   int m_pend = 2;

   int n_chk  = 0;
   int n_pass = 0;

   logic       lit_on    = 1'b0;
   logic [2:0] lit_ftb   = 3'b000;
   logic       rst_probe = 1'b0;

   task automatic model_reset();
      m_busy = 0; m_stop = 0; m_pos = 0; m_n = 2; m_mode = 0; m_pend = 2;
   endtask

   task automatic model_step(input logic e, input logic [7:0] d, input logic l, input logic m);
      int cl;
      cl = (int'(d) < 2) ? 2 : int'(d);
      if (m_busy == 0) begin
         if (e) begin
            m_busy = 1; m_pos = 0; m_stop = 0;
            m_n    = l ? cl : m_pend;
            m_mode = int'(m);
         end
      end else begin
         if (m_pos == m_n - 1) begin
            if (m_stop != 0 && !e) begin
               m_busy = 0; m_pos = 0;
            end else begin
               m_pos  = 0;
               m_n    = l ? cl : m_pend;
               m_mode = int'(m);
            end
         end else begin
            m_pos = m_pos + 1;
         end
         m_stop = (m_busy != 0 && !e) ? 1 : 0;
      end
      if (l) m_pend = cl;
   endtask

   function automatic logic [2:0] model_ftb();
      logic f, t, b;
      b = (m_busy != 0);
      t = b && (m_pos == m_n - 1);
      if (m_mode != 0) f = t;
      else             f = b && (m_pos < (m_n + 1) / 2);
      return {f, t, b};
   endfunction

   task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
      n_chk = n_chk + 1;
      if (act === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got {f,t,b}=%b expected %b at %0t", name, act, exp, $time);
   endtask

   // The single compare process: model every cycle, literals when given,
   // and an immediate probe for asynchronous reset.
   always @(negedge clk_i or posedge rst_probe) begin
      if (rst_probe) begin
         check("async_reset", {f_out_o, tick_o, busy_o}, 3'b000);
      end else if (!rst_i) begin
         check("model", {f_out_o, tick_o, busy_o}, model_ftb());
         if (lit_on) check("literal", {f_out_o, tick_o, busy_o}, lit_ftb);
      end
   end

   task automatic drive(input logic e, input logic [7:0] d, input logic l, input logic m,
                        input logic lo, input logic [2:0] ftb);
      en_i = e; div_i = d; load_i = l; mode_i = m; lit_on = lo; lit_ftb = ftb;
      @(posedge clk_i);
      model_step(e, d, l, m);
      @(negedge clk_i);
      #1;
   endtask

   task automatic cyc(input logic e, input logic [7:0] d, input logic l, input logic m);
      drive(e, d, l, m, 1'b0, 3'b000);
   endtask

   task automatic cycl(input logic e, input logic [7:0] d, input logic l, input logic m,
                       input logic [2:0] ftb);
      drive(e, d, l, m, 1'b1, ftb);
   endtask

   task automatic pulse_reset_probe();
      #1 rst_probe = 1'b1;
      #1 rst_probe = 1'b0;
   endtask

   initial begin
      // reset state
      #1 rst_i = 1'b1;
      pulse_reset_probe();
      model_reset();
      @(negedge clk_i);
      @(negedge clk_i);
      #1 rst_i = 1'b0;

      // default N=2, square
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b101);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b011);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b101);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b011);
      // stop at a boundary: one full period more, then idle
      cyc (1'b0, 8'd0, 1'b0, 1'b0);
      cyc (1'b0, 8'd0, 1'b0, 1'b0);
      cycl(1'b0, 8'd0, 1'b0, 1'b0, 3'b000);
      cycl(1'b0, 8'd0, 1'b0, 1'b0, 3'b000);

      // load 4 in IDLE, then run: 1,1,0,0 with tick on cnt=3
      cycl(1'b0, 8'd4, 1'b1, 1'b0, 3'b000);
      for (int k = 0; k < 2; k++) begin
         cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b101);
         cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b101);
         cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b001);
         cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b011);
      end
      for (int k = 0; k < 5; k++) cyc(1'b0, 8'd0, 1'b0, 1'b0);
      cycl(1'b0, 8'd0, 1'b0, 1'b0, 3'b000);

      // N=5 square, mode to pulse mid-period takes effect next period
      cycl(1'b1, 8'd5, 1'b1, 1'b0, 3'b101);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b101);
      cycl(1'b1, 8'd0, 1'b0, 1'b1, 3'b101);
      cycl(1'b1, 8'd0, 1'b0, 1'b1, 3'b001);
      cycl(1'b1, 8'd0, 1'b0, 1'b1, 3'b011);
      cycl(1'b1, 8'd0, 1'b0, 1'b1, 3'b001);
      cycl(1'b1, 8'd0, 1'b0, 1'b1, 3'b001);
      cycl(1'b1, 8'd0, 1'b0, 1'b1, 3'b001);
      cycl(1'b1, 8'd0, 1'b0, 1'b1, 3'b001);
      cycl(1'b1, 8'd0, 1'b0, 1'b1, 3'b111);
      for (int k = 0; k < 6; k++) cyc(1'b0, 8'd0, 1'b0, 1'b0);
      cycl(1'b0, 8'd0, 1'b0, 1'b0, 3'b000);

      // N=4, load 7 mid-period: 4-cycle period finishes, then 7 (4 high, 3 low)
      cycl(1'b1, 8'd4, 1'b1, 1'b0, 3'b101);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b101);
      cycl(1'b1, 8'd7, 1'b1, 1'b0, 3'b001);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b011);
      for (int k = 0; k < 4; k++) cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b101);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b001);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b001);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b011);
      // loads on the boundary edge apply immediately (7 -> 4, then 4 -> 7)
      cycl(1'b1, 8'd4, 1'b1, 1'b0, 3'b101);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b101);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b001);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b011);
      cycl(1'b1, 8'd7, 1'b1, 1'b0, 3'b101);
      for (int k = 0; k < 3; k++) cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b101);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b001);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b001);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b011);

      // N=6, drop en at cnt=2: finishes to cnt=5, then idle with no runt
      cycl(1'b1, 8'd6, 1'b1, 1'b0, 3'b101);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b101);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b101);
      cycl(1'b0, 8'd0, 1'b0, 1'b0, 3'b001);
      cycl(1'b0, 8'd0, 1'b0, 1'b0, 3'b001);
      cycl(1'b0, 8'd0, 1'b0, 1'b0, 3'b011);
      cycl(1'b0, 8'd0, 1'b0, 1'b0, 3'b000);
      cycl(1'b0, 8'd0, 1'b0, 1'b0, 3'b000);
      // en dips for one cycle mid-period: no interruption
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b101);
      cycl(1'b0, 8'd0, 1'b0, 1'b0, 3'b101);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b101);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b001);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b001);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b011);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b101);

      // N=5 then async reset at cnt=3
      cycl(1'b1, 8'd5, 1'b1, 1'b0, 3'b101);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b101);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b001);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b001);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b011);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b101);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b101);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b101);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b001);
      #1 rst_i = 1'b1;
      pulse_reset_probe();
      model_reset();
      @(negedge clk_i);
      #1 rst_i = 1'b0;
      // pending back at 2
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b101);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b011);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b101);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b011);
      // load 3 on boundary, then div=0 and div=1 both clamp to 2
      cycl(1'b1, 8'd3, 1'b1, 1'b0, 3'b101);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b101);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b011);
      cycl(1'b1, 8'd0, 1'b1, 1'b0, 3'b101);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b011);
      cycl(1'b1, 8'd1, 1'b1, 1'b0, 3'b101);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b011);

      // maximum divisor 255: high 128, low 127, no overflow on wrap
      cycl(1'b1, 8'd255, 1'b1, 1'b0, 3'b101);
      for (int k = 0; k < 126; k++) cyc(1'b1, 8'd0, 1'b0, 1'b0);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b101);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b001);
      for (int k = 0; k < 125; k++) cyc(1'b1, 8'd0, 1'b0, 1'b0);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b011);
      cycl(1'b1, 8'd0, 1'b0, 1'b0, 3'b101);
      // pulse mode at N=255 while draining to idle
      for (int k = 0; k < 260; k++) cyc(1'b0, 8'd0, 1'b0, 1'b1);
      cycl(1'b0, 8'd0, 1'b0, 1'b0, 3'b000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Programmable integer frequency divider.
- Generalises the fixed divide-by-4 flop chain to a WIDTH-bit divisor with two output modes (square or pulse).
- Self-starts from reset, with no enable kick-start trick needed.
- Divisor changes and stops take effect only at period boundaries, so the output never glitches or produces a runt period.
- Feeds slow strobes and divided clocks to downstream lab blocks (counters, blinkers, debouncers).

Parameters:
- WIDTH, 8, width of the divisor and of the internal period counter (WIDTH >= 2).

Ports:
- clk  input  1  system clock; all flops rising-edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  run request; level-sensitive.
- div  input  WIDTH  requested divisor N.
- load  input  1  one-cycle strobe; captures div into the pending register.
- mode  input  1  0 = square output, 1 = pulse output.
- f_out  output  1  divided output; driven directly by a flop.
- tick  output  1  one-cycle strobe on the last cycle of each period; driven directly by a flop.
- busy  output  1  high while in RUN or STOP.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, cnt=0.
  - pending=2, active=2.
  - f_out=0, tick=0, busy=0.
  - Reset takes effect immediately, including mid-period.
- Divisor clamp: a div value of 0 or 1 is stored as 2. Legal N range is 2..2^WIDTH-1.
- Load:
  - On an edge with load=1, pending <= clamp(div).
  - pending is never applied mid-period.
- active is updated from pending only on these edges:
  - IDLE->RUN transition;
  - RUN/STOP period boundary (cnt==active-1).
  - If load=1 on that same edge, active takes clamp(div) directly (bypass). pending is also updated.
- State machine:
  - IDLE:
    - cnt=0, f_out=0, tick=0.
    - Edge with en=1 -> RUN, cnt=0, active<=pending.
  - RUN:
    - Each edge: cnt<=cnt+1, or at cnt==active-1: cnt<=0 and active reload.
    - Edge with en=0 -> STOP; counting continues unchanged.
  - STOP:
    - Counting continues.
    - Edge with en=1 -> RUN; no disturbance to the period.
    - Boundary edge (cnt==active-1) with en=0 -> IDLE.
    - Boundary edge with en=1 -> stays in RUN.
    - The current period always completes.
- Outputs, as a function of the registered cnt/active/mode of the same cycle while in RUN or STOP:
  - H = ceil(active/2).
  - Square mode: f_out=1 iff cnt < H. High time is ceil(N/2) cycles, low time floor(N/2).
  - Pulse mode: f_out=1 iff cnt==active-1.
  - tick=1 iff cnt==active-1, in both modes.
  - In IDLE, f_out=0 and tick=0.
  - f_out and tick must be flop outputs. Compute them from next-state values; no combinational decode on the output.
- mode changes:
  - mode is sampled only at period boundaries, into a mode_active flop that reloads alongside active.
  - A mode change mid-period has no effect until the next period.
- busy = (state != IDLE).
- Latency:
  - First f_out high (square mode) is in the cycle after the first edge that sees en=1.
  - Output period is exactly N clk cycles.
- Wrap: cnt never exceeds active-1. N=2^WIDTH-1 must work with no overflow.

Test Plan:
- Reset then en=1, no load, mode=0:
  - f_out = 1,0,1,0 (N=2 default);
  - tick high every 2nd cycle;
  - busy=1 from the first edge.
- load div=4 in IDLE, then en=1, mode=0:
  - f_out = 1,1,0,0 repeating;
  - tick on every 4th cycle (cnt=3).
- div=5, mode=0:
  - f_out = 1,1,1,0,0;
  - switch mode=1 mid-period -> pulse pattern 0,0,0,0,1 starts only at the next boundary.
- Running N=4, load div=7 at cnt=1:
  - the current period still lasts 4 cycles;
  - the next periods last 7 cycles (high for 4, low for 3).
  - Repeat with load exactly on the boundary edge -> the 7-cycle period starts immediately.
- Running N=6, drop en at cnt=2:
  - counting continues to cnt=5, then IDLE;
  - f_out=0 and busy=0 afterwards; no runt pulse.
  - Re-raise en during STOP -> no interruption.
- rst asserted mid-period (N=5, cnt=3):
  - all outputs 0 immediately;
  - after release and en=1, period is N=2 (pending reset to 2).
  - load div=0 -> behaves as N=2.
